// File: rtl/gray_updn_cnt_if.sv
// Control and status bundle of the Gray up/down counter.
// The counter takes the slave side; whoever drives the controls takes the master side.
interface gray_updn_cnt_if #(
   parameter int unsigned WIDTH = 4
);
   logic             enable;
   logic             up_dn;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_gray;
   logic [WIDTH-1:0] gray;
   logic [WIDTH-1:0] bin;
   logic             wrap;
   logic             at_max;
   logic             at_min;

   modport master (
      output enable, up_dn, clear, load, load_gray,
      input  gray, bin, wrap, at_max, at_min
   );

   modport slave (
      input  enable, up_dn, clear, load, load_gray,
      output gray, bin, wrap, at_max, at_min
   );
endinterface

// File: rtl/gray_updn_cnt.sv
// Up/down Gray counter with clear, Gray-coded parallel load, and wrap or saturate mode.
// Binary and Gray forms are both registered so gray never glitches across domains.
module gray_updn_cnt #(
   parameter int unsigned      WIDTH    = 4,
   parameter bit               WRAP     = 1'b1,
   parameter logic [WIDTH-1:0] INIT_BIN = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   gray_updn_cnt_if.slave  cnt
);
   localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
   localparam logic [WIDTH-1:0] ALL_ONES  = '1;
   localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

   logic [WIDTH-1:0] bin_q,  bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] step_bin;
   logic             at_top;
   logic             at_bot;
   logic             step_wraps;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      load_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         load_bin[i] = ^(cnt.load_gray >> i);
      end
   end

   assign at_top     = (bin_q == ALL_ONES);
   assign at_bot     = (bin_q == '0);
   assign step_bin   = cnt.up_dn ? (bin_q + ONE) : (bin_q - ONE);
   assign step_wraps = cnt.up_dn ? at_top : at_bot;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      bin_d  = bin_q;
      gray_d = gray_q;
      wrap_d = 1'b0;
      if (cnt.clear) begin
         bin_d  = '0;
         gray_d = '0;
      end else if (cnt.load) begin
         bin_d  = load_bin;
         gray_d = cnt.load_gray;
      end else if (cnt.enable && (WRAP || !step_wraps)) begin
         bin_d  = step_bin;
         gray_d = step_bin ^ (step_bin >> 1);
         wrap_d = step_wraps;
      end
   end

   // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= INIT_BIN;
         gray_q <= INIT_GRAY;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   // Range flags decode the registered count only, so they track reset asynchronously too.
   assign cnt.gray   = gray_q;
   assign cnt.bin    = bin_q;
   assign cnt.wrap   = wrap_q;
   assign cnt.at_max = at_top;
   assign cnt.at_min = at_bot;
endmodule

// File: tb/tb_gray_updn_cnt.sv
// Directed bench: three counters (wrap, saturate, INIT_BIN=5) share one stimulus stream;
// each phase checks the instance that exercises the behaviour of interest.
module tb_gray_updn_cnt;
   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       up_dn;
   logic       clear;
   logic       load;
   logic [3:0] load_gray;

   int checks = 0;
   int errors = 0;

   gray_updn_cnt_if #(.WIDTH(4)) if_w ();
   gray_updn_cnt_if #(.WIDTH(4)) if_s ();
   gray_updn_cnt_if #(.WIDTH(4)) if_i ();

   assign if_w.enable = enable;  assign if_w.up_dn = up_dn;  assign if_w.clear = clear;
   assign if_w.load   = load;    assign if_w.load_gray = load_gray;
   assign if_s.enable = enable;  assign if_s.up_dn = up_dn;  assign if_s.clear = clear;
   assign if_s.load   = load;    assign if_s.load_gray = load_gray;
   assign if_i.enable = enable;  assign if_i.up_dn = up_dn;  assign if_i.clear = clear;
   assign if_i.load   = load;    assign if_i.load_gray = load_gray;

   gray_updn_cnt #(.WIDTH(4), .WRAP(1'b1), .INIT_BIN(4'h0)) u_wrap (.clk(clk), .rst_n(rst_n), .cnt(if_w));
   gray_updn_cnt #(.WIDTH(4), .WRAP(1'b0), .INIT_BIN(4'h0)) u_sat  (.clk(clk), .rst_n(rst_n), .cnt(if_s));
   gray_updn_cnt #(.WIDTH(4), .WRAP(1'b1), .INIT_BIN(4'h5)) u_init (.clk(clk), .rst_n(rst_n), .cnt(if_i));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] exp_gray [17] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                    4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};
      logic [3:0] prev_gray;
      logic [3:0] exp_bin;
      logic       sat_wrap_seen;

      rst_n = 1'b0; enable = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_gray = 4'h0;
      #12;
      check("rst_bin",      if_w.bin,    4'h0);
      check("rst_gray",     if_w.gray,   4'h0);
      check("rst_wrap",     if_w.wrap,   1'b0);
      check("rst_at_min",   if_w.at_min, 1'b1);
      check("rst_at_max",   if_w.at_max, 1'b0);
      check("rst_init_bin", if_i.bin,    4'h5);
      check("rst_init_gray",if_i.gray,   4'h7);
      @(negedge clk);
      rst_n = 1'b1;

      // Full up-count with wrap; saturating instance must stick at F.
      enable = 1'b1; up_dn = 1'b1;
      prev_gray = 4'h0;
      sat_wrap_seen = 1'b0;
      for (int i = 0; i < 17; i++) begin
         cycle();
         exp_bin = 4'(i + 1);
         check("up_gray",   if_w.gray,   exp_gray[i]);
         check("up_bin",    if_w.bin,    exp_bin);
         check("up_wrap",   if_w.wrap,   (i == 15));
         check("up_at_max", if_w.at_max, (exp_bin == 4'hF));
         check("up_1bit",   $countones(if_w.gray ^ prev_gray), 1);
         prev_gray = exp_gray[i];
         sat_wrap_seen = sat_wrap_seen | if_s.wrap;
      end
      cycle();
      sat_wrap_seen = sat_wrap_seen | if_s.wrap;
      check("sat_hi_bin",    if_s.bin,      4'hF);
      check("sat_hi_gray",   if_s.gray,     4'h8);
      check("sat_hi_at_max", if_s.at_max,   1'b1);
      check("sat_no_wrap",   sat_wrap_seen, 1'b0);
      check("w_bin_2",       if_w.bin,      4'h2);

      // Down from zero: wrap instance goes to F, saturating instance holds 0.
      enable = 1'b0; clear = 1'b1;
      cycle();
      check("clr_bin", if_w.bin, 4'h0);
      clear = 1'b0; enable = 1'b1; up_dn = 1'b0;
      cycle();
      check("dn_bin",     if_w.bin,    4'hF);
      check("dn_gray",    if_w.gray,   4'h8);
      check("dn_wrap",    if_w.wrap,   1'b1);
      check("dn_at_max",  if_w.at_max, 1'b1);
      check("dn_at_min",  if_w.at_min, 1'b0);
      check("sat_lo_bin", if_s.bin,    4'h0);
      check("sat_lo_gray",if_s.gray,   4'h0);
      check("sat_lo_wrap",if_s.wrap,   1'b0);
      check("sat_lo_min", if_s.at_min, 1'b1);
      enable = 1'b0;
      cycle();
      check("hold_wrap", if_w.wrap, 1'b0);
      check("hold_bin",  if_w.bin,  4'hF);
      check("hold_gray", if_w.gray, 4'h8);

      // Load beats enable, then a normal up step from the loaded value.
      load = 1'b1; load_gray = 4'hD; enable = 1'b1; up_dn = 1'b1;
      cycle();
      check("ld_gray", if_w.gray, 4'hD);
      check("ld_bin",  if_w.bin,  4'h9);
      check("ld_wrap", if_w.wrap, 1'b0);
      load = 1'b0;
      cycle();
      check("ld_up_bin",  if_w.bin,  4'hA);
      check("ld_up_gray", if_w.gray, 4'hF);

      // Clear beats load and enable at bin 7.
      load = 1'b1; load_gray = 4'h4; enable = 1'b0;
      cycle();
      check("ld7_bin", if_w.bin, 4'h7);
      clear = 1'b1; load = 1'b1; load_gray = 4'hD; enable = 1'b1;
      cycle();
      check("clr_pri_bin",  if_w.bin,    4'h0);
      check("clr_pri_gray", if_w.gray,   4'h0);
      check("clr_pri_wrap", if_w.wrap,   1'b0);
      check("clr_pri_min",  if_w.at_min, 1'b1);

      // Clear on what would otherwise be a wrapping step gives no wrap pulse.
      clear = 1'b0; load = 1'b1; load_gray = 4'h8; enable = 1'b0;
      cycle();
      check("ldF_bin", if_w.bin, 4'hF);
      clear = 1'b1; load = 1'b0; enable = 1'b1; up_dn = 1'b1;
      cycle();
      check("clr_wrap", if_w.wrap, 1'b0);
      check("clr_bin2", if_w.bin,  4'h0);

      // Async reset of the INIT_BIN=5 instance mid-count at B.
      clear = 1'b0; load = 1'b1; load_gray = 4'hD; enable = 1'b0;
      cycle();
      check("init_ld_bin", if_i.bin, 4'h9);
      load = 1'b0; enable = 1'b1; up_dn = 1'b1;
      cycle();
      cycle();
      check("init_B_bin",  if_i.bin,  4'hB);
      check("init_B_gray", if_i.gray, 4'hE);
      #2 rst_n = 1'b0;
      #1;
      check("arst_bin",  if_i.bin,  4'h5);
      check("arst_gray", if_i.gray, 4'h7);
      check("arst_wrap", if_i.wrap, 1'b0);
      @(negedge clk);
      check("arst_hold_bin", if_i.bin, 4'h5);
      rst_n = 1'b1;
      cycle();
      check("resume_bin",  if_i.bin,  4'h6);
      check("resume_gray", if_i.gray, 4'h5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
